pmem_accum_ctrl: RTL and testbench
==================================

# pmem_accum_ctrl

Sequencer for the synchronous psum memory (pmem). It accepts a stream of partial sums from the PE array over one or more accumulation passes and performs the read-modify-write into pmem, with signed saturation, at one psum per cycle. After the final pass it drains the accumulated tile to the downstream output stream. It sits between the PE array psum output and the pmem ports.

## Interface
- DATA_WIDTH, 8, psum width, signed two's complement
- ADDR_WIDTH, 8, pmem address width
- DEPTH, 16, maximum psums per tile (implemented pmem entries)
- PASS_WIDTH, 4, width of pass count

- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  pulse; starts a tile when idle
- i_len  in  ADDR_WIDTH  psums per pass, captured on accepted start
- i_num_pass  in  PASS_WIDTH  accumulation passes, captured on accepted start
- i_psum_valid  in  1  psum available
- i_psum_data  in  DATA_WIDTH  psum value
- o_psum_ready  out  1  controller accepts psum
- o_out_valid  out  1  drained word valid
- o_out_data  out  DATA_WIDTH  drained word
- i_out_ready  in  1  downstream accepts word
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse at tile completion
- o_mem_wr_en, o_mem_wr_addr (ADDR_WIDTH), o_mem_wr_data (DATA_WIDTH)  out  pmem write port
- o_mem_rd_en, o_mem_rd_addr (ADDR_WIDTH)  out  pmem read port
- i_mem_rd_data  in  DATA_WIDTH  pmem read data

## Operation
- pmem contract: the read address is captured on i_clk when rd_en is high. The read data is mem[captured addr], combinational. A write committed at edge k is visible on read data in cycle k+1.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE: start is accepted when i_len != 0. The controller captures len = min(i_len, DEPTH) and passes = max(i_num_pass, 1), clears pass/addr counters, and goes to ACCUM. Start with i_len == 0 is ignored. Start in any non-IDLE state is ignored.
- ACCUM: o_psum_ready is high until the last psum of the last pass is accepted. Psums arrive in address order 0..len-1 per pass, and the address wraps to 0 at each pass boundary.
  - Pass 0: the accepted psum goes into stage-1 register (addr, data, first=1). No read is issued.
  - Pass >0: on accept, the controller drives o_mem_rd_en=1 and o_mem_rd_addr=addr in the same cycle. The psum goes into stage 1 with first=0.
  - Stage 1 (next cycle): o_mem_wr_en=1, o_mem_wr_addr=stage addr. o_mem_wr_data = first ? psum : sat(i_mem_rd_data + psum).
  - len==1 back-to-back same address is coherent by the pmem contract, so no forwarding is needed.
- ACCUM→DRAIN when all psums are accepted and stage 1 is empty.
- sat(): signed (DATA_WIDTH+1)-bit sum clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- DRAIN: a read of the next address is issued when reads remain and (!o_out_valid || i_out_ready). o_out_valid is a registered flag set the cycle after a read and cleared when the word is accepted with no new read. o_out_data = i_mem_rd_data. While stalled, no read is issued, so the data holds stable.
- DRAIN→DONE when the word at addr len-1 is accepted. DONE lasts one cycle with o_done=1, then returns to IDLE.
- Reset, including mid-operation: state IDLE, all counters and stage 1 cleared, all outputs 0. pmem contents are not cleared. The first pass of the next tile overwrites them.

## Timing
- Psum accept in cycle t → write commits at the edge ending cycle t+1. Sustained rate is 1 psum/cycle.
- Last accept at t → DRAIN entered at t+2. The first read issues at t+2, so the first o_out_valid is at t+3.
- Drain rate is 1 word/cycle with i_out_ready held high.
- Last drained word accepted at edge e → o_done high in the cycle after e. o_busy falls one cycle after that.
- o_psum_ready is a registered/state decode with no combinational path from i_psum_valid.

## Structure
- Package pmem_ctrl_pkg holds:
  - the state encoding (IDLE/ACCUM/DRAIN/DONE);
  - the saturation bound constants derived from DATA_WIDTH.
- The sub-module pmem_sat_add (signed add plus clamp, combinational) is instantiated once in stage 1.
- The bench pairs the controller with a behavioural pmem model that honours the contract above.

## Test plan
- Single pass: len=4, passes=1, psums 1,2,3,4 → four writes to addr 0..3 with no rd_en in ACCUM; drain outputs 1,2,3,4; one o_done pulse.
- Three passes: len=2, each pass psums 10,-5 → drain outputs 30,-15; full throughput, no ready gaps.
- Saturation and RAW: len=1, passes=2, psums 100,100 back-to-back → drain 127. A repeat run with -100,-100 → drain -128.
- Backpressure: len=3 drain with i_out_ready low for 3 cycles on word 1 → o_out_data stable, o_mem_rd_en=0 during the stall; the output order is intact.
- Reset mid-ACCUM after 2 psums → all outputs 0 and IDLE next cycle. A new start with len=2, passes=1 (psums 7,8) drains 7,8.
- Start rules:
  - i_start while busy → no effect.
  - i_len=0 → stays IDLE.
  - i_len=20 → len clamped to 16, so the drain emits 16 words.

Source files
------------

// File: rtl/pmem_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pmem_ctrl_pkg
// Shared definitions for the psum memory accumulation controller:
//   - controller state encoding (IDLE / ACCUM / DRAIN / DONE)
//   - signed saturation bounds for a given psum width
// No ports (package).
// ----------------------------------------------------------------------------
package pmem_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Largest value representable in a w-bit two's complement word.
    function automatic int sat_max(input int w);
        return (1 <<< (w - 1)) - 1;
    endfunction

    // Smallest value representable in a w-bit two's complement word.
    function automatic int sat_min(input int w);
        return -(1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/pmem_accum_ctrl_if.sv
// ----------------------------------------------------------------------------
// pmem_accum_ctrl_if
// Bundles every non-clock/reset signal of the accumulation controller:
//   - tile control:  i_start, i_len, i_num_pass, o_busy, o_done
//   - psum input stream:  i_psum_valid, i_psum_data, o_psum_ready
//   - drained output stream:  o_out_valid, o_out_data, i_out_ready
//   - pmem write port:  o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data
//   - pmem read port:   o_mem_rd_en, o_mem_rd_addr, i_mem_rd_data
// Modport master is the controller side, slave is the environment side.
// ----------------------------------------------------------------------------
interface pmem_accum_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int PASS_WIDTH = 4
);
    logic                  i_start;
    logic [ADDR_WIDTH-1:0] i_len;
    logic [PASS_WIDTH-1:0] i_num_pass;
    logic                  i_psum_valid;
    logic [DATA_WIDTH-1:0] i_psum_data;
    logic                  o_psum_ready;
    logic                  o_out_valid;
    logic [DATA_WIDTH-1:0] o_out_data;
    logic                  i_out_ready;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_mem_wr_en;
    logic [ADDR_WIDTH-1:0] o_mem_wr_addr;
    logic [DATA_WIDTH-1:0] o_mem_wr_data;
    logic                  o_mem_rd_en;
    logic [ADDR_WIDTH-1:0] o_mem_rd_addr;
    logic [DATA_WIDTH-1:0] i_mem_rd_data;

    modport master (
        input  i_start, i_len, i_num_pass, i_psum_valid, i_psum_data,
               i_out_ready, i_mem_rd_data,
        output o_psum_ready, o_out_valid, o_out_data, o_busy, o_done,
               o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data,
               o_mem_rd_en, o_mem_rd_addr
    );

    modport slave (
        output i_start, i_len, i_num_pass, i_psum_valid, i_psum_data,
               i_out_ready, i_mem_rd_data,
        input  o_psum_ready, o_out_valid, o_out_data, o_busy, o_done,
               o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data,
               o_mem_rd_en, o_mem_rd_addr
    );
endinterface

// File: rtl/pmem_sat_add.sv
// ----------------------------------------------------------------------------
// pmem_sat_add
// Combinational signed add with clamp to the DATA_WIDTH two's complement range.
// Ports:
//   i_a, i_b  signed addends (DATA_WIDTH)
//   o_sum     saturated signed sum (DATA_WIDTH)
// ----------------------------------------------------------------------------
module pmem_sat_add
    import pmem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic signed [DATA_WIDTH-1:0] i_a,
    input  logic signed [DATA_WIDTH-1:0] i_b,
    output logic signed [DATA_WIDTH-1:0] o_sum
);

    localparam logic signed [DATA_WIDTH:0] SAT_HI = (DATA_WIDTH+1)'(sat_max(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH:0] SAT_LO = (DATA_WIDTH+1)'(sat_min(DATA_WIDTH));

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [DATA_WIDTH:0] s);
        logic signed [DATA_WIDTH:0] c;
        if (s > SAT_HI) begin
            c = SAT_HI;
        end else if (s < SAT_LO) begin
            c = SAT_LO;
        end else begin
            c = s;
        end
        return c[DATA_WIDTH-1:0];
    endfunction

    // One extra bit keeps the raw sum exact before clamping.
    logic signed [DATA_WIDTH:0] sum_wide;
    assign sum_wide = {i_a[DATA_WIDTH-1], i_a} + {i_b[DATA_WIDTH-1], i_b};
    assign o_sum    = sat(sum_wide);

endmodule

// File: rtl/pmem_accum_ctrl.sv
// ----------------------------------------------------------------------------
// pmem_accum_ctrl
// Accepts partial sums over one or more passes, read-modify-writes them into
// the synchronous psum memory with signed saturation (1 psum/cycle), then
// drains the accumulated tile onto the output stream.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      pmem_accum_ctrl_if.master: tile control, psum stream,
//            output stream, pmem write and read ports
// ----------------------------------------------------------------------------
module pmem_accum_ctrl
    import pmem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int PASS_WIDTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    pmem_accum_ctrl_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
    localparam logic [PASS_WIDTH-1:0] ONE_P   = PASS_WIDTH'(1);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PASS_WIDTH-1:0] passes_q, passes_d;
    logic [PASS_WIDTH-1:0] pass_q, pass_d;
    logic                  all_acc_q, all_acc_d;
    logic                  out_vld_q, out_vld_d;

    logic                         vld_p1_q;
    logic                         first_p1_q;
    logic [ADDR_WIDTH-1:0]        addr_p1_q;
    logic signed [DATA_WIDTH-1:0] psum_p1_q;

    logic                         psum_rdy;
    logic                         psum_acc;
    logic                         last_addr;
    logic                         last_pass;
    logic                         drain_rd;
    logic                         rd_en;
    logic signed [DATA_WIDTH-1:0] rd_data_s;
    logic signed [DATA_WIDTH-1:0] sum_p1;

    // Ready is a pure state decode; it drops once the final psum is taken.
    assign psum_rdy  = (state_q == ST_ACCUM) && !all_acc_q;
    assign psum_acc  = psum_rdy && bus.i_psum_valid;
    assign last_addr = (addr_q == len_q - ONE_A);
    assign last_pass = (pass_q == passes_q - ONE_P);

    // In DRAIN addr_q counts issued reads; a new read is only allowed when the
    // held word is empty or leaving, so stalled data never changes.
    assign drain_rd  = (state_q == ST_DRAIN) && (addr_q != len_q) &&
                       (!out_vld_q || bus.i_out_ready);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        passes_d  = passes_q;
        pass_d    = pass_q;
        addr_d    = addr_q;
        all_acc_d = all_acc_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start && (bus.i_len != '0)) begin
                    len_d     = (bus.i_len > DEPTH_A) ? DEPTH_A : bus.i_len;
                    passes_d  = (bus.i_num_pass == '0) ? ONE_P : bus.i_num_pass;
                    pass_d    = '0;
                    addr_d    = '0;
                    all_acc_d = 1'b0;
                    state_d   = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (psum_acc) begin
                    if (last_addr) begin
                        addr_d = '0;
                        if (last_pass) begin
                            all_acc_d = 1'b1;
                        end else begin
                            pass_d = pass_q + ONE_P;
                        end
                    end else begin
                        addr_d = addr_q + ONE_A;
                    end
                end
                // The final write is in stage 1 this cycle and commits at this
                // edge, so the first drain read may be issued next cycle.
                if (all_acc_q) begin
                    all_acc_d = 1'b0;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_rd) begin
                    addr_d = addr_q + ONE_A;
                end
                if (out_vld_q && bus.i_out_ready && (addr_q == len_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        if (drain_rd) begin
            out_vld_d = 1'b1;
        end else if (bus.i_out_ready) begin
            out_vld_d = 1'b0;
        end else begin
            out_vld_d = out_vld_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            passes_q   <= '0;
            pass_q     <= '0;
            addr_q     <= '0;
            all_acc_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            vld_p1_q   <= 1'b0;
            first_p1_q <= 1'b0;
            addr_p1_q  <= '0;
            psum_p1_q  <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            passes_q  <= passes_d;
            pass_q    <= pass_d;
            addr_q    <= addr_d;
            all_acc_q <= all_acc_d;
            out_vld_q <= out_vld_d;
            // Stage 1: accepted psum waits here while pmem returns the old value.
            vld_p1_q  <= psum_acc;
            if (psum_acc) begin
                addr_p1_q  <= addr_q;
                psum_p1_q  <= bus.i_psum_data;
                first_p1_q <= (pass_q == '0);
            end
        end
    end

    assign rd_data_s = bus.i_mem_rd_data;

    pmem_sat_add #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sat_add (
        .i_a   (rd_data_s),
        .i_b   (psum_p1_q),
        .o_sum (sum_p1)
    );

    // Pass 0 overwrites stale tile contents, so it needs no read.
    assign rd_en = (psum_acc && (pass_q != '0)) || drain_rd;

    assign bus.o_psum_ready  = psum_rdy;
    assign bus.o_mem_rd_en   = rd_en;
    assign bus.o_mem_rd_addr = rd_en ? addr_q : '0;
    assign bus.o_mem_wr_en   = vld_p1_q;
    assign bus.o_mem_wr_addr = vld_p1_q ? addr_p1_q : '0;
    assign bus.o_mem_wr_data = !vld_p1_q ? '0 : (first_p1_q ? psum_p1_q : sum_p1);
    assign bus.o_out_valid   = out_vld_q;
    assign bus.o_out_data    = out_vld_q ? bus.i_mem_rd_data : '0;
    assign bus.o_busy        = (state_q != ST_IDLE);
    assign bus.o_done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_pmem_accum_ctrl.sv
module tb_pmem_accum_ctrl;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int DEPTH = 16;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pmem_accum_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PASS_WIDTH(PW)) bus ();

    pmem_accum_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .PASS_WIDTH (PW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Behavioural pmem: address captured on rd_en, data combinational.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] rd_cap = '0;
    always @(posedge clk) begin
        if (bus.o_mem_wr_en) mem[bus.o_mem_wr_addr] <= bus.o_mem_wr_data;
        if (bus.o_mem_rd_en) rd_cap <= bus.o_mem_rd_addr;
    end
    assign bus.i_mem_rd_data = mem[rd_cap];

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];
    int psum_q[$];
    int words_seen = 0;
    int done_cnt = 0;
    int ready_mode = 0;
    int stall_cnt = 0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // Output-side driver for i_out_ready.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: bus.i_out_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (bus.o_out_valid && words_seen == 1 && stall_cnt < 3) begin
                    bus.i_out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    bus.i_out_ready = 1'b1;
                end
            end
            default: bus.i_out_ready = 1'b1;
        endcase
    end

    // Monitor: pops expected drain words, checks stall behaviour, counts done.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_out_valid && !bus.i_out_ready) begin
                check("stall_rd_en", int'(bus.o_mem_rd_en), 0);
                if (prev_stall) check("stall_data", int'($signed(bus.o_out_data)), int'($signed(prev_data)));
            end
            if (bus.o_out_valid && bus.i_out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL drain_extra: got word %0d expected none", int'($signed(bus.o_out_data)));
                end else begin
                    check("drain_word", int'($signed(bus.o_out_data)), exp_q.pop_front());
                end
                words_seen++;
            end
            if (bus.o_done) done_cnt++;
            prev_stall = bus.o_out_valid && !bus.i_out_ready;
            prev_data  = bus.o_out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Offer one psum (optionally after random idle cycles); entered and left at posedge+1.
    task automatic offer(input int v, input int pass, input int addr, input int gaps, input bit busy_start);
        if (gaps != 0) begin
            while ($urandom_range(0, 3) == 0) begin
                bus.i_psum_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        bus.i_psum_valid = 1'b1;
        bus.i_psum_data  = DW'(v);
        if (busy_start) begin
            bus.i_start    = 1'b1;
            bus.i_len      = AW'(5);
            bus.i_num_pass = PW'(1);
        end
        @(negedge clk);
        check("psum_ready", int'(bus.o_psum_ready), 1);
        check("accum_rd_en", int'(bus.o_mem_rd_en), (pass != 0) ? 1 : 0);
        if (pass != 0) check("accum_rd_addr", int'(bus.o_mem_rd_addr), addr);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
    endtask

    task automatic pulse_start(input int len_in, input int np);
        bus.i_start    = 1'b1;
        bus.i_len      = AW'(len_in);
        bus.i_num_pass = PW'(np);
        @(posedge clk); #1;
        bus.i_start    = 1'b0;
        bus.i_len      = AW'($urandom_range(0, 255));
        bus.i_num_pass = PW'($urandom_range(0, 15));
    endtask

    // Runs a whole tile; psums come from psum_q unless rnd is set.
    task automatic run_tile(input int len_in, input int np, input bit rnd, input int gaps,
                            input bit busy_start, input int rmode);
        int eff_len;
        int ep;
        int acc[DEPTH];
        int t;
        eff_len = (len_in > DEPTH) ? DEPTH : len_in;
        ep = (np == 0) ? 1 : np;
        if (rnd) begin
            psum_q.delete();
            for (int i = 0; i < eff_len * ep; i++) psum_q.push_back(int'($urandom_range(0, 255)) - 128);
        end
        for (int p = 0; p < ep; p++)
            for (int a = 0; a < eff_len; a++)
                acc[a] = (p == 0) ? psum_q[p*eff_len + a] : clamp(acc[a] + psum_q[p*eff_len + a]);
        for (int a = 0; a < eff_len; a++) exp_q.push_back(acc[a]);
        ready_mode = rmode;
        stall_cnt  = 0;
        words_seen = 0;
        done_cnt   = 0;
        pulse_start(len_in, np);
        for (int p = 0; p < ep; p++)
            for (int a = 0; a < eff_len; a++)
                offer(psum_q[p*eff_len + a], p, a, gaps, busy_start && (p*eff_len + a == 1));
        bus.i_psum_valid = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.o_done && t < 3000);
        if (t >= 3000) begin
            check("done_timeout", 0, 1);
        end else begin
            check("busy_at_done", int'(bus.o_busy), 1);
            @(negedge clk);
            check("busy_after_done", int'(bus.o_busy), 0);
            check("done_width", int'(bus.o_done), 0);
        end
        check("words_left", exp_q.size(), 0);
        check("done_pulses", done_cnt, 1);
        check("words_drained", words_seen, eff_len);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        bus.i_start      = 1'b0;
        bus.i_len        = '0;
        bus.i_num_pass   = '0;
        bus.i_psum_valid = 1'b0;
        bus.i_psum_data  = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", int'(bus.o_psum_ready), 0);
        check("rst_out_valid", int'(bus.o_out_valid), 0);
        check("rst_busy", int'(bus.o_busy), 0);
        check("rst_done", int'(bus.o_done), 0);
        check("rst_wr_en", int'(bus.o_mem_wr_en), 0);
        check("rst_rd_en", int'(bus.o_mem_rd_en), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single pass 1,2,3,4
        psum_q = '{1, 2, 3, 4};
        run_tile(4, 1, 1'b0, 0, 1'b0, 0);
        // Three passes of 10,-5
        psum_q = '{10, -5, 10, -5, 10, -5};
        run_tile(2, 3, 1'b0, 0, 1'b0, 0);
        // Saturation with len==1 back-to-back read-after-write
        psum_q = '{100, 100};
        run_tile(1, 2, 1'b0, 0, 1'b0, 0);
        psum_q = '{-100, -100};
        run_tile(1, 2, 1'b0, 0, 1'b0, 0);
        // Backpressure on word 1
        psum_q = '{5, -6, 7};
        run_tile(3, 1, 1'b0, 0, 1'b0, 2);
        check("stall_cycles", stall_cnt, 3);

        // Reset mid-ACCUM after two psums
        pulse_start(4, 1);
        offer(11, 0, 0, 0, 1'b0);
        offer(12, 0, 1, 0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", int'(bus.o_busy), 0);
        check("midrst_ready", int'(bus.o_psum_ready), 0);
        check("midrst_wr_en", int'(bus.o_mem_wr_en), 0);
        check("midrst_rd_en", int'(bus.o_mem_rd_en), 0);
        check("midrst_out_valid", int'(bus.o_out_valid), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        psum_q = '{7, 8};
        run_tile(2, 1, 1'b0, 0, 1'b0, 0);

        // Start with len 0 is ignored
        pulse_start(0, 2);
        @(negedge clk);
        check("len0_busy", int'(bus.o_busy), 0);
        @(negedge clk);
        check("len0_ready", int'(bus.o_psum_ready), 0);
        @(posedge clk); #1;

        // Start while busy ignored; len clamped to DEPTH
        run_tile(6, 2, 1'b1, 0, 1'b1, 0);
        run_tile(20, 2, 1'b1, 1, 1'b0, 1);

        for (int k = 0; k < 6; k++)
            run_tile(int'($urandom_range(1, 16)), int'($urandom_range(0, 4)), 1'b1, 1, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
